// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, default
// width and iteration-counter width.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } divState_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// The partial remainder is one bit wider than the operands so the shifted
// value can never wrap before it is compared against the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_dvsExt;

  assign w_shifted = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
  assign w_dvsExt  = {1'b0, i_dvs};

  // Shift the next dividend bit in, then subtract and set the quotient bit when it fits
  always_comb begin
    o_quo = {i_quo[WIDTH-2:0], 1'b0};
    o_rem = w_shifted;
    if (w_shifted >= w_dvsExt) begin
      o_rem    = w_shifted - w_dvsExt;
      o_quo[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed/unsigned divide sequencer: IDLE -> ABS -> DIV x WIDTH -> FIX.
// lo holds the quotient, hi the remainder; both change only on a done pulse.
// Optional feature macro: DIV_ZERO_TRAP_EN adds o_div_zero and skips the
// iteration phase when the divisor is zero.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic             o_div_zero
`endif
);

  localparam logic [CNT_W:0] LAST_CNT = (CNT_W+1)'(WIDTH - 1);

  divState_t        r_state;
  logic [CNT_W:0]   r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_isSigned;
  logic             r_dvdNeg;
  logic             r_dvsNeg;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_absDvs;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   w_nextRem;
  logic [WIDTH-1:0] w_nextQuo;
  logic             w_dvsZero;
`ifdef DIV_ZERO_TRAP_EN
  logic             r_divZero;
`endif

  assign w_dvsZero = (r_dvs == '0);

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem(r_rem),
    .i_quo(r_quo),
    .i_dvs(r_absDvs),
    .o_rem(w_nextRem),
    .o_quo(w_nextQuo)
  );

  // Sequencer: latch operands, take magnitudes, iterate, then sign-correct and publish
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_isSigned <= 1'b0;
      r_dvdNeg   <= 1'b0;
      r_dvsNeg   <= 1'b0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_absDvs   <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
`ifdef DIV_ZERO_TRAP_EN
      r_divZero  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_isSigned <= i_is_signed;
            r_dvd      <= i_dividend;
            r_dvs      <= i_divisor;
            r_dvdNeg   <= i_is_signed & i_dividend[WIDTH-1];
            r_dvsNeg   <= i_is_signed & i_divisor[WIDTH-1];
            r_busy     <= 1'b1;
            r_state    <= ABS;
          end
        end
        ABS: begin
          r_quo    <= r_dvdNeg ? (~r_dvd + 1'b1) : r_dvd;
          r_absDvs <= r_dvsNeg ? (~r_dvs + 1'b1) : r_dvs;
          r_rem    <= '0;
          r_cnt    <= '0;
`ifdef DIV_ZERO_TRAP_EN
          r_state  <= w_dvsZero ? FIX : DIV;
`else
          r_state  <= DIV;
`endif
        end
        DIV: begin
          r_rem <= w_nextRem;
          r_quo <= w_nextQuo;
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FIX: begin
          if (w_dvsZero) begin
            r_lo <= '1;
            r_hi <= r_dvd;
          end else begin
            r_lo <= (r_dvdNeg ^ r_dvsNeg) ? (~r_quo + 1'b1) : r_quo;
            r_hi <= r_dvdNeg ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
          end
`ifdef DIV_ZERO_TRAP_EN
          r_divZero <= w_dvsZero;
`endif
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = (r_state == IDLE);
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_lo    = r_lo;
  assign o_hi    = r_hi;
`ifdef DIV_ZERO_TRAP_EN
  assign o_div_zero = r_divZero;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is presented.
// Honours DIV_ZERO_TRAP_EN the same way as the design.
module tb_div_seq_ctrl;

  localparam int W = 32;
  localparam int FULL_LAT = W + 2;
`ifdef DIV_ZERO_TRAP_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = W + 2;
`endif

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int           acceptCyc;
    int           lat;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         isSigned;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         divZero;

  exp_t sbQ[$];
  int   cyc = 0;
  int   testsRun = 0;
  int   testsFailed = 0;

  div_seq_ctrl #(
    .WIDTH(W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_is_signed(isSigned),
    .i_dividend(dividend),
    .i_divisor(divisor),
    .o_ready(ready),
    .o_busy(busy),
    .o_done(done),
    .o_lo(lo),
    .o_hi(hi)
`ifdef DIV_ZERO_TRAP_EN
    ,
    .o_div_zero(divZero)
`endif
  );

`ifndef DIV_ZERO_TRAP_EN
  assign divZero = 1'b0;
`endif

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure start-to-done latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Caller is positioned just after a negedge; waits (bounded) for ready, then issues one request
  task automatic applyStimulus(input logic sgn, input logic [W-1:0] dvd,
                               input logic [W-1:0] dvs, input logic [W-1:0] expLo,
                               input logic [W-1:0] expHi, input logic expDz,
                               input int expLat);
    exp_t e;
    int   guard;
    guard = 0;
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_before_start", {31'd0, ready}, 32'd1);
    isSigned    = sgn;
    dividend    = dvd;
    divisor     = dvs;
    start       = 1'b1;
    e.lo        = expLo;
    e.hi        = expHi;
    e.dz        = expDz;
    e.acceptCyc = cyc + 1;
    e.lat       = expLat;
    sbQ.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Leaves the caller at the negedge where done is seen, or flags a timeout
  task automatic waitDone();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!done && guard < 200);
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL done_timeout: got no done expected done within 200 cycles");
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_done: got done with lo=%h hi=%h expected no done", lo, hi);
      end else begin
        e = sbQ.pop_front();
        checkOutput("lo", lo, e.lo);
        checkOutput("hi", hi, e.hi);
        checkOutput("latency", W'(cyc - e.acceptCyc), W'(e.lat));
`ifdef DIV_ZERO_TRAP_EN
        checkOutput("div_zero", {31'd0, divZero}, {31'd0, e.dz});
`endif
      end
    end
  end

  initial begin : stimulus
    int busyCount;
    rst      = 1'b1;
    start    = 1'b0;
    isSigned = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);

    checkOutput("reset_busy",  {31'd0, busy},  32'd0);
    checkOutput("reset_done",  {31'd0, done},  32'd0);
    checkOutput("reset_ready", {31'd0, ready}, 32'd1);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7 signed with busy profile
    applyStimulus(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, FULL_LAT);
    busyCount = 0;
    @(negedge clk);
    checkOutput("ready_while_busy", {31'd0, ready}, 32'd0);
    while (!done && busyCount < 100) begin
      if (busy) busyCount++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", W'(busyCount), W'(FULL_LAT));
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);

    applyStimulus(1'b1, -32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, FULL_LAT);
    waitDone();
    @(negedge clk);
    applyStimulus(1'b1, 32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2, 1'b0, FULL_LAT);
    waitDone();
    @(negedge clk);
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, FULL_LAT);
    waitDone();
    @(negedge clk);
    applyStimulus(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, FULL_LAT);
    waitDone();
    @(negedge clk);

    // Unsigned with a stray start pulse mid-operation
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 1'b0, FULL_LAT);
    repeat (9) @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    waitDone();

    // Back-to-back: next request issued in the done cycle
    @(negedge clk);
    applyStimulus(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, FULL_LAT);
    waitDone();
    applyStimulus(1'b1, -32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, FULL_LAT);
    waitDone();
    @(negedge clk);

    // Divide by zero
    applyStimulus(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, ZERO_LAT);
    waitDone();
    @(negedge clk);

    // Reset in the middle of an operation
    applyStimulus(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, FULL_LAT);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    void'(sbQ.pop_front());
    checkOutput("midrst_busy",  {31'd0, busy},  32'd0);
    checkOutput("midrst_done",  {31'd0, done},  32'd0);
    checkOutput("midrst_ready", {31'd0, ready}, 32'd1);
    checkOutput("midrst_lo", lo, 32'd0);
    checkOutput("midrst_hi", hi, 32'd0);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    checkOutput("pending_results", W'(sbQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
